dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, byte-address width shared with the data memory.
REQ-002 Parameter MAX_WAIT, default 4, number of lost arbitrations after which port 1 is forced to win.
REQ-003 Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, i_rst_n.
REQ-004 Port list, in order:
- clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_req0  in  1  port 0 (CPU LSU) request
- i_we0  in  1  port 0 write (1) / read (0)
- i_addr0  in  ADDR_WIDTH  port 0 byte address
- i_size0  in  2  port 0 size: 01 byte, 10 half, 11 word
- i_wdata0  in  32  port 0 write data
- o_gnt0  out  1  port 0 grant pulse
- o_rvalid0  out  1  port 0 read-data valid pulse
- o_rdata0  out  32  port 0 read data
- i_req1, i_we1, i_addr1, i_size1, i_wdata1, o_gnt1, o_rvalid1, o_rdata1: same widths and meanings, for port 1 (debug/loader)
- o_mem_waddr  out  ADDR_WIDTH  memory write address
- o_mem_raddr  out  ADDR_WIDTH  memory read address
- o_mem_size  out  2  memory access size
- o_mem_wen  out  1  memory write enable
- o_mem_ren  out  1  memory read enable
- o_mem_din  out  32  memory write data
- i_mem_dout  in  32  memory read data, valid one clock after raddr/ren are presented and while they are held

Function
REQ-005 FSM states: IDLE, GRANT, RWAIT, RDONE; reset state is IDLE.
REQ-006 In IDLE with any request pending, at the clock edge:
- latch the winner's we/addr/size/wdata
- go to GRANT
REQ-007 Arbitration: port 0 wins, except that port 1 wins when only port 1 requests, or when wait_cnt equals MAX_WAIT.
REQ-008 wait_cnt:
- increments, saturating at MAX_WAIT, on each arbitration port 1 loses while requesting
- clears when port 1 is granted
REQ-009 In GRANT:
- o_gntN = 1 for the winner, exactly one cycle
- o_mem_waddr and o_mem_raddr = latched address
- o_mem_size = latched size
- for a write: o_mem_wen = 1 and o_mem_din = latched data, next state IDLE
- for a read: o_mem_ren = 1, next state RWAIT
REQ-010 In RWAIT, o_mem_ren and o_mem_raddr are held; i_mem_dout is registered into the winner's o_rdataN at the edge; next state RDONE.
REQ-011 In RDONE:
- o_rvalidN = 1 for one cycle
- o_mem_ren = 0
- next state IDLE
REQ-012 Latencies from a request sampled in IDLE at cycle T:
- gnt in T+1 for read or write
- write committed at the end of T+1
- rvalid in T+3
REQ-013 o_rdataN holds its value until the next read completes on that port; it is never cleared by writes or by the other port.
REQ-014 Requesters hold req and command stable until gnt; a request dropped before gnt is ignored, with no memory access.
REQ-015 Requests arriving outside IDLE wait; at most one transaction is in flight; o_gnt0 and o_gnt1 are never high together.
REQ-016 i_size is passed through unchanged; alignment and byte-lane handling belong to the memory.
REQ-017 o_mem_wen and o_mem_ren are never high in the same cycle.

Reset
REQ-018 Asserting i_rst_n low in any state, including mid-read, drives the FSM to IDLE and clears wait_cnt.
REQ-019 While i_rst_n is low, all outputs are 0, including o_rdata0/1 and o_mem_din; an in-flight transaction is dropped with no rvalid.
REQ-020 The first arbitration occurs at the first clock edge after i_rst_n deasserts.

Structure
REQ-021 The shared package holds:
- state encoding (IDLE=0, GRANT=1, RWAIT=2, RDONE=3)
- size codes SZ_BYTE=01, SZ_HALF=10, SZ_WORD=11
REQ-022 One sub-module, dmem_arb_pick: combinational winner selection from req0, req1 and the wait_cnt==MAX_WAIT flag; the FSM and datapath stay in dmem_arbiter.
REQ-023 The bench instantiates dmem_arbiter with the existing memory module.

Verification
REQ-024 Port 0 SW 0x11223344 to addr 0x010, then LW from 0x010: gnt0 in T+1, rvalid0 in T+3, rdata0 = 0x11223344.
REQ-025 req0 and req1 both high in IDLE: gnt0 first; port 1 granted on the first IDLE cycle after port 0's transaction.
REQ-026 req0 held continuously, req1 held, MAX_WAIT=4: port 1 granted on the 5th arbitration, then wait_cnt = 0.
REQ-027 Port 1 SH 0xBEEF at addr 0x006, then port 0 LW at addr 0x004: rdata0[31:16] = 0xBEEF; o_rdata1 unchanged.
REQ-028 i_rst_n pulsed low in RWAIT: no rvalid; all outputs 0 during reset; state IDLE after release; the next read completes normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and codes for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RWAIT = 2'd2,
        RDONE = 2'd3
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Command fields captured from the winning port at arbitration.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
    } cmd_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select: port 0 has priority unless port 1 is alone
// or has been starved long enough (force1).
module dmem_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic force1,
    output logic any,
    output logic win1
);

    assign any  = req0 | req1;
    assign win1 = req1 & (~req0 | force1);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single data memory. One transaction in
// flight; reads take GRANT -> RWAIT -> RDONE, writes commit in GRANT.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0,
    input  logic                  i_we0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [1:0]            i_size0,
    input  logic [31:0]           i_wdata0,
    output logic                  o_gnt0,
    output logic                  o_rvalid0,
    output logic [31:0]           o_rdata0,
    input  logic                  i_req1,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [1:0]            i_size1,
    input  logic [31:0]           i_wdata1,
    output logic                  o_gnt1,
    output logic                  o_rvalid1,
    output logic [31:0]           o_rdata1,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    output logic [1:0]            o_mem_size,
    output logic                  o_mem_wen,
    output logic                  o_mem_ren,
    output logic [31:0]           o_mem_din,
    input  logic [31:0]           i_mem_dout
);

    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    arb_state_e            state, state_nx;
    cmd_t                  cmd_q, cmd_sel;
    logic [ADDR_WIDTH-1:0] addr_q, addr_sel;
    logic                  win1_q;
    logic [WCW-1:0]        wait_cnt;
    logic [1:0][31:0]      rdata_q;
    logic                  any, win1, arb;

    dmem_arb_pick u_pick (
        .req0   (i_req0),
        .req1   (i_req1),
        .force1 (wait_cnt == WAIT_MAX),
        .any    (any),
        .win1   (win1)
    );

    // An arbitration happens only on an IDLE cycle with something pending.
    assign arb      = (state == IDLE) && any;
    assign cmd_sel  = win1 ? '{we: i_we1, size: i_size1, wdata: i_wdata1}
                           : '{we: i_we0, size: i_size0, wdata: i_wdata0};
    assign addr_sel = win1 ? i_addr1 : i_addr0;

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Capture the winner's command; it drives the memory for the whole txn.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q  <= '0;
            addr_q <= '0;
            win1_q <= 1'b0;
        end else if (arb) begin
            cmd_q  <= cmd_sel;
            addr_q <= addr_sel;
            win1_q <= win1;
        end
    end

    // Starvation counter for port 1: counts lost arbitrations, clears on win.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt <= '0;
        end else if (arb) begin
            if (win1)                              wait_cnt <= '0;
            else if (i_req1 && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Read data lands in the winner's holding register; the other port keeps its value.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)              rdata_q <= '0;
        else if (state == RWAIT)   rdata_q[win1_q] <= i_mem_dout;
    end

    assign o_rdata0 = rdata_q[0];
    assign o_rdata1 = rdata_q[1];

    // Next state and memory/handshake outputs decoded from the state.
    always_comb begin
        state_nx    = state;
        o_gnt0      = 1'b0;
        o_gnt1      = 1'b0;
        o_rvalid0   = 1'b0;
        o_rvalid1   = 1'b0;
        o_mem_waddr = '0;
        o_mem_raddr = '0;
        o_mem_size  = '0;
        o_mem_wen   = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_din   = '0;
        case (state)
            IDLE: begin
                if (any) state_nx = GRANT;
            end
            GRANT: begin
                o_gnt0      = ~win1_q;
                o_gnt1      = win1_q;
                o_mem_waddr = addr_q;
                o_mem_raddr = addr_q;
                o_mem_size  = cmd_q.size;
                if (cmd_q.we) begin
                    o_mem_wen = 1'b1;
                    o_mem_din = cmd_q.wdata;
                    state_nx  = IDLE;
                end else begin
                    o_mem_ren = 1'b1;
                    state_nx  = RWAIT;
                end
            end
            RWAIT: begin
                // Memory output is valid only while raddr/ren stay put.
                o_mem_ren   = 1'b1;
                o_mem_raddr = addr_q;
                o_mem_size  = cmd_q.size;
                state_nx    = RDONE;
            end
            RDONE: begin
                o_rvalid0 = ~win1_q;
                o_rvalid1 = win1_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed memory model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [1:0]    size0, size1;
    logic [31:0]   wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0]   rdata0, rdata1;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [1:0]    mem_size;
    logic          mem_wen, mem_ren;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;
    logic          mem_clr;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
        .clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_size0(size0), .i_wdata0(wdata0),
        .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_size1(size1), .i_wdata1(wdata1),
        .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
        .o_mem_waddr(mem_waddr), .o_mem_raddr(mem_raddr), .o_mem_size(mem_size),
        .o_mem_wen(mem_wen), .o_mem_ren(mem_ren), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout)
    );

    // Memory model: little-endian bytes, size-aware writes, registered word reads.
    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] ra;
    assign ra = {mem_raddr[AW-1:2], 2'b00};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
        end else if (mem_wen) begin
            mem[mem_waddr] <= mem_din[7:0];
            if (mem_size != SZ_BYTE) mem[mem_waddr + 10'd1] <= mem_din[15:8];
            if (mem_size == SZ_WORD) begin
                mem[mem_waddr + 10'd2] <= mem_din[23:16];
                mem[mem_waddr + 10'd3] <= mem_din[31:24];
            end
        end
        if (mem_ren) mem_dout <= {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set0(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [1:0] s, input logic [31:0] d);
        req0 = r; we0 = w; addr0 = a; size0 = s; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [1:0] s, input logic [31:0] d);
        req1 = r; we1 = w; addr1 = a; size1 = s; wdata1 = d;
    endtask

    // Every output must be zero while reset is held.
    task automatic chk_all_zero(input string tag);
        chk({tag, "_hs"}, 32'({gnt0, gnt1, rvalid0, rvalid1, mem_wen, mem_ren}), 32'd0);
        chk({tag, "_rdata0"}, rdata0, 32'd0);
        chk({tag, "_rdata1"}, rdata1, 32'd0);
        chk({tag, "_din"}, mem_din, 32'd0);
        chk({tag, "_addr"}, 32'({mem_waddr, mem_raddr, mem_size}), 32'd0);
    endtask

    initial begin
        int ng, first1, second1, both, rv_seen;
        rst_n = 1'b0; mem_clr = 1'b1;
        set0(1'b0, 1'b0, '0, 2'b00, '0);
        set1(1'b0, 1'b0, '0, 2'b00, '0);
        tick(); tick();
        chk_all_zero("reset");
        mem_clr = 1'b0;
        rst_n   = 1'b1;

        // Port 0 SW then LW: gnt at T+1, write in T+1, rvalid at T+3.
        set0(1'b1, 1'b1, 10'h010, SZ_WORD, 32'h11223344);
        tick();
        chk("sw_gnt0", 32'(gnt0), 32'd1);
        chk("sw_wen", 32'({mem_wen, mem_ren}), 32'd2);
        chk("sw_din", mem_din, 32'h11223344);
        chk("sw_waddr", 32'(mem_waddr), 32'h010);
        chk("sw_size", 32'(mem_size), 32'd3);
        set0(1'b0, 1'b0, '0, 2'b00, '0);
        tick();
        chk("sw_idle", 32'({gnt0, mem_wen}), 32'd0);
        set0(1'b1, 1'b0, 10'h010, SZ_WORD, '0);
        tick();
        chk("lw_gnt0", 32'(gnt0), 32'd1);
        chk("lw_ren", 32'({mem_wen, mem_ren}), 32'd1);
        chk("lw_raddr", 32'(mem_raddr), 32'h010);
        set0(1'b0, 1'b0, '0, 2'b00, '0);
        tick();
        chk("lw_rwait", 32'({mem_ren, rvalid0, gnt0}), 32'd4);
        chk("lw_rwait_raddr", 32'(mem_raddr), 32'h010);
        tick();
        chk("lw_rvalid0", 32'({rvalid0, rvalid1, mem_ren}), 32'd4);
        chk("lw_rdata0", rdata0, 32'h11223344);
        tick();
        chk("lw_after", 32'(rvalid0), 32'd0);

        // Both request: port 0 first, port 1 on the next IDLE arbitration.
        set0(1'b1, 1'b1, 10'h020, SZ_WORD, 32'hA5A5A5A5);
        set1(1'b1, 1'b1, 10'h024, SZ_WORD, 32'h5A5A0001);
        tick();
        chk("both_gnt", 32'({gnt0, gnt1}), 32'd2);
        set0(1'b0, 1'b0, '0, 2'b00, '0);
        tick();
        chk("both_idle", 32'({gnt0, gnt1}), 32'd0);
        tick();
        chk("both_gnt1", 32'({gnt0, gnt1}), 32'd1);
        chk("both_waddr1", 32'(mem_waddr), 32'h024);
        set1(1'b0, 1'b0, '0, 2'b00, '0);
        tick();

        // Starvation: port 1 wins the 5th arbitration, then counter restarts.
        set0(1'b1, 1'b1, 10'h030, SZ_WORD, 32'h00000001);
        set1(1'b1, 1'b1, 10'h034, SZ_WORD, 32'h00000002);
        ng = 0; first1 = 0; second1 = 0; both = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (gnt0 && gnt1) both = 1;
            if (gnt0 || gnt1) ng++;
            if (gnt1) begin
                if (first1 == 0) first1 = ng;
                else             second1 = ng;
            end
            if (second1 != 0) break;
        end
        set0(1'b0, 1'b0, '0, 2'b00, '0);
        set1(1'b0, 1'b0, '0, 2'b00, '0);
        chk("starve_first", 32'(first1), 32'd5);
        chk("starve_second", 32'(second1), 32'd10);
        chk("gnt_excl", 32'(both), 32'd0);
        tick();

        // Port 1 reads a known word so its holding register has a value.
        set1(1'b1, 1'b0, 10'h024, SZ_WORD, '0);
        tick();
        chk("p1_lw_gnt1", 32'({gnt0, gnt1}), 32'd1);
        set1(1'b0, 1'b0, '0, 2'b00, '0);
        tick(); tick();
        chk("p1_lw_rvalid", 32'({rvalid0, rvalid1}), 32'd1);
        chk("p1_lw_rdata1", rdata1, 32'h5A5A0001);
        tick();

        // Port 1 SH 0xBEEF at 0x006, port 0 LW 0x004 sees it in the upper half.
        set1(1'b1, 1'b1, 10'h006, SZ_HALF, 32'h0000BEEF);
        tick();
        chk("sh_gnt1", 32'(gnt1), 32'd1);
        chk("sh_size", 32'(mem_size), 32'd2);
        set1(1'b0, 1'b0, '0, 2'b00, '0);
        tick();
        set0(1'b1, 1'b0, 10'h004, SZ_WORD, '0);
        tick();
        chk("lw4_gnt0", 32'(gnt0), 32'd1);
        set0(1'b0, 1'b0, '0, 2'b00, '0);
        tick(); tick();
        chk("lw4_rvalid", 32'({rvalid0, rvalid1}), 32'd2);
        chk("lw4_rdata0", rdata0, 32'hBEEF0000);
        chk("lw4_rdata1_kept", rdata1, 32'h5A5A0001);
        tick();

        // Reset pulse in RWAIT: transaction dropped, outputs zero, then normal read.
        set0(1'b1, 1'b0, 10'h010, SZ_WORD, '0);
        tick();
        chk("rst_rd_gnt0", 32'(gnt0), 32'd1);
        set0(1'b0, 1'b0, '0, 2'b00, '0);
        tick();
        chk("rst_rd_rwait", 32'(mem_ren), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        chk_all_zero("rst_hold");
        rst_n = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rvalid0 || rvalid1 || gnt0 || gnt1) rv_seen = 1;
        end
        chk("rst_no_rvalid", 32'(rv_seen), 32'd0);
        set0(1'b1, 1'b0, 10'h010, SZ_WORD, '0);
        tick();
        chk("post_rst_gnt0", 32'(gnt0), 32'd1);
        set0(1'b0, 1'b0, '0, 2'b00, '0);
        tick(); tick();
        chk("post_rst_rvalid0", 32'(rvalid0), 32'd1);
        chk("post_rst_rdata0", rdata0, 32'h11223344);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Simulation time bound.
    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
